mapper_ss_sequencer: RTL and testbench
======================================

Name: mapper_ss_sequencer

Overview:
- Controller for the mapper savestate register bus (64-bit data, 10-bit register index, wren/rst/load strobes).
- Save: walks a contiguous range of register indices, reads each word back over the bus and writes it to external savestate memory through a req/ack handshake.
- Load: fetches words from memory, writes them into the registers, then issues one load strobe so the mappers commit the values.
- Clear: pulses the bus reset.
- Sits between the top-level savestate manager and all mapper modules.

Parameters:
- BASE_INDEX, 10'd32, first register index in the walk.
- NUM_REGS, 4, number of consecutive indices to walk (1..64).
- MEM_AW, 16, savestate memory word-address width.
- MEM_BASE, 0, memory word address of the first register word.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_save  in  1  single-cycle start-save request
- cmd_load  in  1  single-cycle start-load request
- cmd_clear  in  1  single-cycle clear request
- busy  out  1  high while any operation is in progress
- done  out  1  one-cycle pulse when an operation completes
- error  out  1  sticky until next command; checksum failure (feature only, else 0)
- SaveStateBus_Din  out  64  write data to registers
- SaveStateBus_Adr  out  10  register index
- SaveStateBus_wren  out  1  register write strobe
- SaveStateBus_rst  out  1  register reset strobe
- SaveStateBus_load  out  1  commit strobe
- SaveStateBus_Dout  in  64  OR-combined read data from all mappers
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; stable while mem_req is high
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  64  write data
- mem_rdata  in  64  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle acknowledge

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; index counter clears to 0; all outputs are 0.
- SaveStateBus_Adr is 0 in IDLE.
- Commands are sampled only in IDLE; commands arriving while busy are dropped.
- Simultaneous commands: priority is clear > load > save.
- busy goes high the cycle after a command is accepted and stays high until the cycle done pulses.
- States: IDLE, CLEAR, S_ADR, S_MEM, L_MEM, L_WR, L_APPLY, FIN.
- CLEAR: rst=1 for exactly 1 cycle, then FIN.
- S_ADR:
  - Adr=BASE_INDEX+i.
  - Hold 1 cycle so the bus read data settles.
  - Capture Dout into the wdata register at the end of that cycle, then go to S_MEM.
- S_MEM:
  - mem_req=1, mem_we=1, mem_addr=MEM_BASE+i.
  - On mem_ack: if i==NUM_REGS-1 go to FIN; else i++ and go back to S_ADR.
- L_MEM:
  - mem_req=1, mem_we=0, mem_addr=MEM_BASE+i.
  - On mem_ack, latch mem_rdata into Din, then go to L_WR.
- L_WR:
  - Adr=BASE_INDEX+i, wren=1 for 1 cycle.
  - Then: if last index go to L_APPLY; else i++ and go to L_MEM.
- L_APPLY: load=1 for exactly 1 cycle, then FIN.
- FIN: done=1 for 1 cycle, i clears to 0, back to IDLE.
- Strobe exclusivity: wren, rst and load are never high in the same cycle.
- Hold rules: mem_req never drops before mem_ack. Adr and Din stay stable for the whole cycle in which wren is high.
- Index and address arithmetic:
  - The index counter is 6 bits. Adr is 10 bits and truncated on overflow; no wrap checking.
  - mem_addr is MEM_AW bits and truncated.
- mem_ack with mem_req low is ignored.
- There is no timeout; only reset aborts an operation.
- Reset mid-load before L_APPLY: registers may be partially written, but load is never pulsed.
- Minimum cycle counts with zero-wait ack: save takes 2 cycles per register + 1; load takes 2 per register + 2.

Optional Feature:
- Macro: MAPPER_SS_CHECKSUM_EN.
- When defined, save:
  - Keeps a running XOR of all saved words.
  - After the last register, does one extra memory write of that XOR at MEM_BASE+NUM_REGS.
- When defined, load:
  - Accumulates the XOR of the loaded words.
  - Then reads MEM_BASE+NUM_REGS and compares it with the accumulated XOR.
  - Mismatch: error=1, L_APPLY is skipped (no load strobe), go to FIN.
  - Match: L_APPLY as normal.
- When not defined: no extra memory access, error is tied to 0.

Decomposition:
- Package mapper_ss_pkg holds:
  - SS_DW=64, SS_AW=10;
  - the state enum ss_state_t;
  - the priority encoding of the commands.
- One natural sub-module: mapper_ss_memport, which implements the req/ack holding register (req, we, addr, wdata, rdata latch) and signals completion to the FSM.

Test Plan:
- Clear: cmd_clear with zero-wait ack → rst high for exactly 1 cycle, done 2 cycles after the command, no mem_req.
- Save, NUM_REGS=4, BASE_INDEX=32:
  - Stimulus: bus model returns 64'hA0+idx, mem_ack delayed 3 cycles.
  - Required: memory holds words 0..3 = A0,A1,A2,A3; Adr visits 32..35; done pulses once.
- Load:
  - Stimulus: memory preloaded with 11,22,33,44.
  - Required: four wren pulses with Adr 32..35 and matching Din, then exactly one load pulse after the last wren, then done.
- Command while busy and simultaneous commands:
  - cmd_save during a load → ignored; only a load occurs.
  - cmd_load and cmd_save in the same cycle in IDLE → load runs.
- Reset mid-op: reset asserted during the L_MEM of index 2 → all outputs 0 immediately; load never pulses; a subsequent save works.
- MAPPER_SS_CHECKSUM_EN:
  - Save writes XOR(A0..A3) at address 4.
  - Corrupt word 1, then load → error=1 and no load pulse.
  - Uncorrupted load → error=0 and load pulse issued.

Source files
------------

// File: rtl/mapper_ss_pkg.sv
// mapper_ss_pkg: shared widths, FSM states and command priority for the savestate sequencer.
// MAPPER_SS_CHECKSUM_EN enables the trailing XOR checksum word on save/load.
package mapper_ss_pkg;

    localparam int SS_DW = 64;
    localparam int SS_AW = 10;

`ifdef MAPPER_SS_CHECKSUM_EN
    localparam bit SS_CHK_EN = 1'b1;
`else
    localparam bit SS_CHK_EN = 1'b0;
`endif

    // S_SUM / L_SUM are only reachable when the checksum is enabled
    typedef enum logic [3:0] {
        IDLE, CLEAR, S_ADR, S_MEM, L_MEM, L_WR, L_APPLY, FIN, S_SUM, L_SUM
    } ss_state_t;

    typedef enum logic [1:0] {CMD_NONE, CMD_SAVE, CMD_LOAD, CMD_CLEAR} ss_cmd_t;

    function automatic ss_cmd_t ss_cmd_decode(input logic save, input logic load, input logic clear);
        return clear ? CMD_CLEAR : load ? CMD_LOAD : save ? CMD_SAVE : CMD_NONE;
    endfunction

endpackage

// File: rtl/mapper_ss_memport.sv
// mapper_ss_memport: req/ack holding register; launches on start, holds until ack,
// latches read data and reports completion in the ack cycle.
module mapper_ss_memport
    import mapper_ss_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [SS_DW-1:0]  wdata,
    output logic              done,
    output logic [SS_DW-1:0]  rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [SS_DW-1:0]  mem_wdata,
    input  logic [SS_DW-1:0]  mem_rdata,
    input  logic              mem_ack
);

    logic              req_q, req_d, we_q, we_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [SS_DW-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;

    always_comb begin
        done    = req_q & mem_ack;
        req_d   = start ? 1'b1 : done ? 1'b0 : req_q;
        we_d    = start ? we : we_q;
        addr_d  = start ? addr : addr_q;
        wdata_d = start ? wdata : wdata_q;
        rdata_d = (done && !we_q) ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: rtl/mapper_ss_sequencer.sv
// mapper_ss_sequencer: walks the mapper savestate bus for save/load/clear operations.
// Define MAPPER_SS_CHECKSUM_EN to append and verify an XOR checksum word.
module mapper_ss_sequencer
    import mapper_ss_pkg::*;
#(
    parameter logic [SS_AW-1:0] BASE_INDEX = 10'd32,
    parameter int               NUM_REGS   = 4,
    parameter int               MEM_AW     = 16,
    parameter int               MEM_BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_save,
    input  logic              cmd_load,
    input  logic              cmd_clear,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [SS_DW-1:0]  SaveStateBus_Din,
    output logic [SS_AW-1:0]  SaveStateBus_Adr,
    output logic              SaveStateBus_wren,
    output logic              SaveStateBus_rst,
    output logic              SaveStateBus_load,
    input  logic [SS_DW-1:0]  SaveStateBus_Dout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [SS_DW-1:0]  mem_wdata,
    input  logic [SS_DW-1:0]  mem_rdata,
    input  logic              mem_ack
);

    localparam logic [5:0]        LAST     = 6'(NUM_REGS - 1);
    localparam logic [MEM_AW-1:0] SUM_ADDR = MEM_AW'(MEM_BASE + NUM_REGS);

    function automatic logic [MEM_AW-1:0] mem_at(input logic [5:0] i);
        return MEM_AW'(MEM_BASE) + MEM_AW'(i);
    endfunction

    ss_state_t         state_q, state_d;
    ss_cmd_t           cmd;
    logic [5:0]        idx_q, idx_d;
    logic [SS_DW-1:0]  sum_q, sum_d;
    logic              err_q, err_d;
    logic              mp_start, mp_we, mp_done, last;
    logic [MEM_AW-1:0] mp_addr;
    logic [SS_DW-1:0]  mp_wdata;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        err_d    = err_q;
        mp_start = 1'b0;
        mp_we    = 1'b0;
        mp_addr  = mem_at(idx_q);
        mp_wdata = SaveStateBus_Dout;
        last     = idx_q == LAST;
        cmd      = ss_cmd_decode(cmd_save, cmd_load, cmd_clear);
        case (state_q)
            IDLE: begin
                state_d  = cmd == CMD_CLEAR ? CLEAR : cmd == CMD_LOAD ? L_MEM :
                           cmd == CMD_SAVE ? S_ADR : IDLE;
                mp_start = cmd == CMD_LOAD;
                if (cmd != CMD_NONE) begin
                    sum_d = '0;
                    err_d = 1'b0;
                end
            end
            CLEAR: state_d = FIN;
            // bus read data has settled by the end of this cycle; launch the write with it
            S_ADR: begin
                mp_start = 1'b1;
                mp_we    = 1'b1;
                sum_d    = sum_q ^ SaveStateBus_Dout;
                state_d  = S_MEM;
            end
            S_MEM: if (mp_done) begin
                if (!last) begin
                    idx_d   = idx_q + 6'd1;
                    state_d = S_ADR;
                end else if (SS_CHK_EN) begin
                    mp_start = 1'b1;
                    mp_we    = 1'b1;
                    mp_addr  = SUM_ADDR;
                    mp_wdata = sum_q;
                    state_d  = S_SUM;
                end else begin
                    state_d = FIN;
                end
            end
            S_SUM: state_d = mp_done ? FIN : S_SUM;
            L_MEM: if (mp_done) begin
                sum_d   = sum_q ^ mem_rdata;
                state_d = L_WR;
            end
            L_WR: begin
                mp_start = !last || SS_CHK_EN;
                mp_addr  = last ? SUM_ADDR : mem_at(idx_q + 6'd1);
                idx_d    = last ? idx_q : idx_q + 6'd1;
                state_d  = !last ? L_MEM : SS_CHK_EN ? L_SUM : L_APPLY;
            end
            L_SUM: if (mp_done) begin
                err_d   = mem_rdata != sum_q;
                state_d = mem_rdata != sum_q ? FIN : L_APPLY;
            end
            L_APPLY: state_d = FIN;
            FIN: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    mapper_ss_memport #(.MEM_AW(MEM_AW)) u_memport (
        .clk       (clk),
        .reset     (reset),
        .start     (mp_start),
        .we        (mp_we),
        .addr      (mp_addr),
        .wdata     (mp_wdata),
        .done      (mp_done),
        .rdata     (SaveStateBus_Din),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    assign busy              = state_q != IDLE;
    assign done              = state_q == FIN;
    assign error             = SS_CHK_EN & err_q;
    assign SaveStateBus_Adr  = (state_q == S_ADR || state_q == L_WR) ? BASE_INDEX + SS_AW'(idx_q) : '0;
    assign SaveStateBus_wren = state_q == L_WR;
    assign SaveStateBus_rst  = state_q == CLEAR;
    assign SaveStateBus_load = state_q == L_APPLY;

endmodule

// File: tb/tb_mapper_ss_sequencer.sv
// tb_mapper_ss_sequencer: randomized bus/memory models with a list-based reference of each operation.
module tb_mapper_ss_sequencer;

    localparam int         N    = 4;
    localparam logic [9:0] BASE = 10'd32;
`ifdef MAPPER_SS_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        cmd_save = 1'b0, cmd_load = 1'b0, cmd_clear = 1'b0;
    logic        busy, done, error, ss_wren, ss_rst, ss_load, mem_req, mem_we;
    logic        mem_ack = 1'b0;
    logic [63:0] ss_din, ss_dout, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic [9:0]  ss_adr;
    logic [15:0] mem_addr;

    logic [63:0] bus_regs [N];
    logic [63:0] mem [16];
    int n_checks = 0, n_err = 0;
    int cyc = 0, ack_dly = 0, ack_cnt = 0, t;
    int viol, rst_cnt, load_cnt, done_cnt, mem_wr_cnt, mem_rd_cnt;
    int load_cyc, done_cyc, last_wren_cyc, busy_rise, cmd_cyc;
    logic [9:0]  adr_q[$], wr_adr_q[$];
    logic [63:0] wr_din_q[$];
    logic prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0, prev_busy = 1'b0;

    mapper_ss_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_save          (cmd_save),
        .cmd_load          (cmd_load),
        .cmd_clear         (cmd_clear),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .SaveStateBus_Din  (ss_din),
        .SaveStateBus_Adr  (ss_adr),
        .SaveStateBus_wren (ss_wren),
        .SaveStateBus_rst  (ss_rst),
        .SaveStateBus_load (ss_load),
        .SaveStateBus_Dout (ss_dout),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack)
    );

    always #5 clk = ~clk;

    always_comb begin
        ss_dout = 64'h0;
        for (int i = 0; i < N; i++)
            if (int'(ss_adr) == int'(BASE) + i) ss_dout = bus_regs[i];
    end

    // protocol monitor and memory model, both sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (int'(ss_wren) + int'(ss_rst) + int'(ss_load) > 1) viol++;
            if (prev_req && !prev_ack && (!mem_req || mem_we != prev_we)) viol++;
            if (!busy && ss_adr != 10'd0) viol++;
            if (mem_req && mem_addr > 16'd15) viol++;
            if (ss_wren) begin
                wr_adr_q.push_back(ss_adr);
                wr_din_q.push_back(ss_din);
                last_wren_cyc = cyc;
            end else if (ss_adr != 10'd0) adr_q.push_back(ss_adr);
            if (ss_rst) rst_cnt++;
            if (ss_load) begin load_cnt++; load_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy && !prev_busy) busy_rise = cyc;
        end
        if (reset || mem_ack) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end else if (mem_req) begin
            if (ack_cnt >= ack_dly) begin
                mem_ack = 1'b1;
                if (mem_we) begin mem[mem_addr[3:0]] = mem_wdata; mem_wr_cnt++; end
                else mem_rd_cnt++;
                mem_rdata = mem[mem_addr[3:0]];
            end else ack_cnt++;
        end
        prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we; prev_busy = busy;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"}, 64'({busy, done, error, ss_wren, ss_rst, ss_load, mem_req, mem_we, ss_adr, mem_addr}), 64'd0);
        check({tag, "_din"}, ss_din, 64'd0);
        check({tag, "_wdata"}, mem_wdata, 64'd0);
    endtask

    task automatic clear_log();
        viol = 0; rst_cnt = 0; load_cnt = 0; done_cnt = 0; mem_wr_cnt = 0; mem_rd_cnt = 0;
        load_cyc = -1; done_cyc = -1; last_wren_cyc = -1; busy_rise = -1;
        adr_q.delete(); wr_adr_q.delete(); wr_din_q.delete();
    endtask

    task automatic issue(input logic s, input logic l, input logic c);
        @(posedge clk); #2;
        cmd_save = s; cmd_load = l; cmd_clear = c; cmd_cyc = cyc + 1;
        @(posedge clk); #2;
        cmd_save = 1'b0; cmd_load = 1'b0; cmd_clear = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin @(negedge clk); k++; end
        check("op_completes", 64'(done_cnt != 0), 64'd1);
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic run_save(input int dly);
        logic [63:0] x = '0;
        clear_log();
        ack_dly = dly;
        for (int i = 0; i < 16; i++) mem[i] = 64'hDEAD_0000 + 64'(i);
        issue(1'b1, 1'b0, 1'b0);
        wait_done(300);
        for (int i = 0; i < N; i++) begin
            check("save_mem", mem[i], bus_regs[i]);
            x ^= bus_regs[i];
        end
        check("save_sum_word", mem[N], CHK != 0 ? x : 64'hDEAD_0000 + 64'(N));
        check("save_adr_cnt", 64'(adr_q.size()), 64'(N));
        for (int i = 0; i < adr_q.size() && i < N; i++) check("save_adr", 64'(adr_q[i]), 64'(BASE) + 64'(i));
        check("save_done_cnt", 64'(done_cnt), 64'd1);
        check("save_mem_wr", 64'(mem_wr_cnt), 64'(N + CHK));
        check("save_mem_rd", 64'(mem_rd_cnt), 64'd0);
        check("save_no_wren", 64'(wr_adr_q.size() + load_cnt), 64'd0);
        check("save_proto", 64'(viol), 64'd0);
        if (dly == 0) check("save_cycles", 64'(done_cyc - cmd_cyc), 64'(2 * N + 1 + CHK));
    endtask

    task automatic run_load(input int dly);
        logic [63:0] snap [16];
        logic [63:0] x = '0;
        logic        exp_err;
        snap = mem;
        for (int i = 0; i < N; i++) x ^= mem[i];
        exp_err = CHK != 0 && x != mem[N];
        clear_log();
        ack_dly = dly;
        issue(1'b0, 1'b1, 1'b0);
        wait_done(300);
        check("load_wren_cnt", 64'(wr_adr_q.size()), 64'(N));
        for (int i = 0; i < wr_adr_q.size() && i < N; i++) begin
            check("load_adr", 64'(wr_adr_q[i]), 64'(BASE) + 64'(i));
            check("load_din", wr_din_q[i], snap[i]);
        end
        check("load_strobe_cnt", 64'(load_cnt), exp_err ? 64'd0 : 64'd1);
        check("load_order", 64'(load_cnt == 0 || (load_cyc > last_wren_cyc && done_cyc > load_cyc)), 64'd1);
        check("load_error", 64'(error), 64'(exp_err));
        check("load_done_cnt", 64'(done_cnt), 64'd1);
        check("load_mem_rd", 64'(mem_rd_cnt), 64'(N + CHK));
        check("load_mem_wr", 64'(mem_wr_cnt), 64'd0);
        check("load_proto", 64'(viol), 64'd0);
        if (dly == 0) check("load_cycles", 64'(done_cyc - cmd_cyc), 64'(2 * N + 2 + CHK - int'(exp_err)));
    endtask

    initial begin
        for (int i = 0; i < N; i++) bus_regs[i] = 64'hA0 + 64'(i);
        for (int i = 0; i < 16; i++) mem[i] = '0;
        clear_log();
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        reset = 1'b0;

        clear_log();
        ack_dly = 0;
        issue(1'b0, 1'b0, 1'b1);
        wait_done(50);
        check("clr_rst_cnt", 64'(rst_cnt), 64'd1);
        check("clr_done_lat", 64'(done_cyc - cmd_cyc), 64'd2);
        check("clr_busy_rise", 64'(busy_rise - cmd_cyc), 64'd1);
        check("clr_no_mem", 64'(mem_wr_cnt + mem_rd_cnt), 64'd0);
        check("clr_proto", 64'(viol), 64'd0);

        run_save(3);

        mem[0] = 64'h11; mem[1] = 64'h22; mem[2] = 64'h33; mem[3] = 64'h44;
        mem[4] = 64'h11 ^ 64'h22 ^ 64'h33 ^ 64'h44;
        run_load(0);

        run_save(0);
        mem[1] ^= 64'h1;
        run_load(1);
        mem[1] ^= 64'h1;
        run_load(0);

        clear_log();
        ack_dly = 2;
        issue(1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        cmd_save = 1'b1;
        @(posedge clk);
        #2;
        cmd_save = 1'b0;
        wait_done(300);
        repeat (20) @(posedge clk);
        #2;
        check("busy_drop_wren", 64'(wr_adr_q.size()), 64'(N));
        check("busy_drop_memwr", 64'(mem_wr_cnt), 64'd0);
        check("busy_drop_done", 64'(done_cnt), 64'd1);
        check("busy_drop_load", 64'(load_cnt), 64'd1);

        clear_log();
        issue(1'b1, 1'b1, 1'b0);
        wait_done(300);
        check("prio_load_wren", 64'(wr_adr_q.size()), 64'(N));
        check("prio_load_memwr", 64'(mem_wr_cnt), 64'd0);

        clear_log();
        issue(1'b1, 1'b1, 1'b1);
        wait_done(300);
        check("prio_clear_rst", 64'(rst_cnt), 64'd1);
        check("prio_clear_idle", 64'(wr_adr_q.size() + mem_wr_cnt + mem_rd_cnt), 64'd0);

        clear_log();
        ack_dly = 2;
        issue(1'b0, 1'b1, 1'b0);
        t = 0;
        while (!(mem_req && !mem_we && mem_addr == 16'd2) && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("rst_reach_idx2", 64'(t < 100), 64'd1);
        #1 reset = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("rst_no_load", 64'(load_cnt), 64'd0);
        check("rst_no_done", 64'(done_cnt), 64'd0);
        check("rst_partial_wren", 64'(wr_adr_q.size()), 64'd2);
        for (int i = 0; i < N; i++) bus_regs[i] = {$urandom, $urandom};
        run_save(0);

        repeat (8) begin
            for (int i = 0; i < N; i++) bus_regs[i] = {$urandom, $urandom};
            run_save(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) mem[$urandom_range(0, N - 1)] ^= 64'h1 << $urandom_range(0, 63);
            run_load(int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
